// File: rtl/matrix_result_writer_if.sv
// Result stream interface for matrix_result_writer.
// The producer (PE controller) drives master; the writer drives slave.
interface matrix_result_writer_if;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;

    modport master (output res_valid, output res_data, input res_ready);
    modport slave  (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/matrix_result_writer.sv
// matrix_result_writer: buffers NUM_ROWS result beats in a small FIFO and writes
// them sequentially into result BRAM starting at BASE_ADDR, then pulses done.
// Optional feature macro: MATRIX_RESULT_FLAG_EN adds a FLAG state that writes
// 32'h1 to BASE_ADDR+(NUM_ROWS<<2) for one cycle before DONE.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; no writes, res_ready low
// S_RUN  | accepting beats and draining the FIFO into BRAM
// S_FLAG | completion word on the BRAM port (MATRIX_RESULT_FLAG_EN only)
// S_DONE | one-cycle done pulse, returns to S_IDLE
module matrix_result_writer #(
    parameter int          NUM_ROWS   = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          start,
    matrix_result_writer_if.slave         res,
    output logic [31:0]                   BRAM_ADDR,
    output logic [31:0]                   BRAM_WRDATA,
    output logic [3:0]                    BRAM_WE,
    output logic                          busy,
    output logic                          done
);

    localparam int            AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW    = $clog2(NUM_ROWS + 1);
    localparam logic [CW-1:0] ROWS  = CW'(NUM_ROWS);
    localparam logic [AW:0]   DEPTH = (AW + 1)'(FIFO_DEPTH);
`ifdef MATRIX_RESULT_FLAG_EN
    localparam logic [31:0]   FLAG_ADDR = BASE_ADDR + (32'(NUM_ROWS) << 2);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FLAG = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state, state_nxt;

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   fifo_cnt;
    logic [CW-1:0] acc_cnt, wr_cnt;

    logic          fifo_full, fifo_empty;
    logic          push, pop, job_start, rows_written;

    assign fifo_full     = (fifo_cnt == DEPTH);
    assign fifo_empty    = (fifo_cnt == '0);
    assign rows_written  = (wr_cnt == ROWS);
    assign job_start     = (state == S_IDLE) && start;
    assign res.res_ready = (state == S_RUN) && !fifo_full && (acc_cnt < ROWS);
    assign push          = res.res_valid && res.res_ready;
    assign pop           = (state == S_RUN) && !fifo_empty && (wr_cnt < ROWS);

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
`ifdef MATRIX_RESULT_FLAG_EN
                if (rows_written) state_nxt = S_FLAG;
`else
                if (rows_written) state_nxt = S_DONE;
`endif
            end
            S_FLAG: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge aclk) begin
        if (push) fifo_mem[wr_ptr] <= res.res_data;
    end

    // FIFO pointers and occupancy; push and pop together leave occupancy unchanged.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Accepted-beat and written-word counters, cleared when a job begins.
    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_cnt <= '0;
            wr_cnt  <= '0;
        end else if (job_start) begin
            acc_cnt <= '0;
            wr_cnt  <= '0;
        end else begin
            if (push) acc_cnt <= acc_cnt + CW'(1);
            if (pop)  wr_cnt  <= wr_cnt + CW'(1);
        end
    end

    // Registered BRAM port: one word per pop, address idles at zero between writes.
    always_ff @(posedge aclk) begin
        if (areset) begin
            BRAM_ADDR   <= '0;
            BRAM_WRDATA <= '0;
            BRAM_WE     <= '0;
        end else begin
            BRAM_ADDR <= '0;
            BRAM_WE   <= 4'h0;
            if (pop) begin
                BRAM_WE     <= 4'hF;
                BRAM_WRDATA <= fifo_mem[rd_ptr];
                BRAM_ADDR   <= BASE_ADDR + (32'(wr_cnt) << 2);
            end
`ifdef MATRIX_RESULT_FLAG_EN
            // Loaded on the RUN->FLAG edge so the flag word sits on the port during FLAG.
            else if ((state == S_RUN) && rows_written) begin
                BRAM_WE     <= 4'hF;
                BRAM_WRDATA <= 32'h0000_0001;
                BRAM_ADDR   <= FLAG_ADDR;
            end
`endif
        end
    end

endmodule

// File: tb/tb_matrix_result_writer.sv
// Self-checking bench for matrix_result_writer (NUM_ROWS=16, FIFO_DEPTH=4, BASE_ADDR=0x100).
module tb_matrix_result_writer;

    localparam int          NR   = 16;
    localparam int          FD   = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef MATRIX_RESULT_FLAG_EN
    localparam int          FLAG_W = 1;
`else
    localparam int          FLAG_W = 0;
`endif

    logic        aclk   = 1'b0;
    logic        areset = 1'b1;
    logic        start  = 1'b0;
    logic [31:0] BRAM_ADDR, BRAM_WRDATA;
    logic [3:0]  BRAM_WE;
    logic        busy, done;

    matrix_result_writer_if rif ();

    matrix_result_writer #(
        .NUM_ROWS   (NR),
        .FIFO_DEPTH (FD),
        .BASE_ADDR  (BASE)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .start       (start),
        .res         (rif),
        .BRAM_ADDR   (BRAM_ADDR),
        .BRAM_WRDATA (BRAM_WRDATA),
        .BRAM_WE     (BRAM_WE),
        .busy        (busy),
        .done        (done)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    int          w_cyc[$];
    logic [31:0] w_addr[$];
    logic [31:0] w_data[$];
    int          d_cyc[$];
    int          a_edge[$];
    logic [31:0] vals[$];
    int          bad_we = 0, bad_idle_addr = 0, bad_ready = 0;

    // Observe the BRAM port, done pulses and handshakes mid-cycle.
    always @(negedge aclk) begin
        if (BRAM_WE != 4'h0) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(BRAM_ADDR);
            w_data.push_back(BRAM_WRDATA);
            if (BRAM_WE != 4'hF) bad_we++;
        end else if (BRAM_ADDR != 32'h0) begin
            bad_idle_addr++;
        end
        if (done) d_cyc.push_back(cyc);
        if (rif.res_valid && rif.res_ready) a_edge.push_back(cyc + 1);
        if (rif.res_ready && !busy) bad_ready++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        w_cyc.delete();
        w_addr.delete();
        w_data.delete();
        d_cyc.delete();
        a_edge.delete();
    endtask

    task automatic fill_vals(input int n, input int mode, input logic [31:0] base_val);
        vals.delete();
        for (int i = 0; i < n; i++) begin
            if (mode == 0) vals.push_back(base_val + 32'(i));
            else           vals.push_back($urandom());
        end
    endtask

    // Producer: offers vals[0..n-1] in order, holding each until accepted, with
    // random idle gaps. Called and returns at posedge+1.
    task automatic run_job(input int n, input int gap_max, input int spur_it,
                           input int stop_writes, output int accepted, output bit saw_done);
        int k   = 0;
        int gap = 0;
        accepted = 0;
        saw_done = 1'b0;
        start = 1'b1;
        rif.res_valid = 1'b0;
        @(posedge aclk); #1;
        start = 1'b0;
        for (int it = 0; it < 400; it++) begin
            start = (it == spur_it);
            if (gap > 0) begin
                rif.res_valid = 1'b0;
                gap--;
            end else if (k < n) begin
                rif.res_valid = 1'b1;
                rif.res_data  = vals[k];
            end else begin
                rif.res_valid = 1'b0;
            end
            @(negedge aclk); #1;
            if (rif.res_valid && rif.res_ready) begin
                accepted++;
                k++;
                gap = $urandom_range(0, gap_max);
            end
            if (done) saw_done = 1'b1;
            if (stop_writes > 0 && w_data.size() >= stop_writes) areset = 1'b1;
            @(posedge aclk); #1;
            if (saw_done || areset) break;
        end
        start = 1'b0;
        rif.res_valid = 1'b0;
    endtask

    // Reference: the written vector is the first NUM_ROWS offered values at
    // consecutive word addresses, optionally followed by the flag word.
    task automatic check_job(input string tag);
        chk({tag, ":nwrites"}, w_data.size(), NR + FLAG_W);
        for (int i = 0; i < NR && i < w_data.size(); i++) begin
            chk($sformatf("%s:addr%0d", tag, i), w_addr[i], BASE + 32'(i * 4));
            chk($sformatf("%s:data%0d", tag, i), w_data[i], vals[i]);
        end
`ifdef MATRIX_RESULT_FLAG_EN
        if (w_data.size() == NR + 1) begin
            chk({tag, ":flag_addr"}, w_addr[NR], BASE + 32'(NR * 4));
            chk({tag, ":flag_data"}, w_data[NR], 32'h1);
            chk({tag, ":flag_cyc"}, w_cyc[NR], w_cyc[NR-1] + 1);
        end
`endif
        chk({tag, ":ndone"}, d_cyc.size(), 1);
        if (d_cyc.size() == 1 && w_cyc.size() == NR + FLAG_W)
            chk({tag, ":done_cyc"}, d_cyc[0], w_cyc[NR-1] + 1 + FLAG_W);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, ":nacc_edges"}, a_edge.size(), NR);
        for (int i = 1; i < NR && i < a_edge.size(); i++)
            chk($sformatf("%s:acc_edge%0d", tag, i), a_edge[i], a_edge[0] + i);
        for (int i = 1; i < NR && i < w_cyc.size(); i++)
            chk($sformatf("%s:wr_cyc%0d", tag, i), w_cyc[i], w_cyc[0] + i);
        if (a_edge.size() > 0 && w_cyc.size() > 0)
            chk({tag, ":latency"}, w_cyc[0], a_edge[0] + 1);
    endtask

    initial begin
        int acc;
        bit sd;
        int nb;
        int gm;
        string tg;

        // Reset held 3 cycles with valid high.
        areset = 1'b1;
        rif.res_valid = 1'b1;
        rif.res_data  = 32'hFFFF_FFFF;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst:ready", rif.res_ready, 1'b0);
        chk("rst:we", BRAM_WE, 4'h0);
        chk("rst:busy", busy, 1'b0);
        chk("rst:done", done, 1'b0);
        chk("rst:addr", BRAM_ADDR, 32'h0);
        chk("rst:wrdata", BRAM_WRDATA, 32'h0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("idle:ready", rif.res_ready, 1'b0);
        chk("idle:busy", busy, 1'b0);

        // start and reset together: reset wins.
        @(posedge aclk); #1;
        areset = 1'b1;
        start  = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        start  = 1'b0;
        rif.res_valid = 1'b0;
        @(negedge aclk);
        chk("rst_start:busy", busy, 1'b0);
        @(posedge aclk); #1;

        // Streaming: data = i, back-to-back.
        fill_vals(NR, 0, 32'h0);
        clear_logs();
        run_job(NR, 0, -1, 0, acc, sd);
        chk("stream:done_seen", sd, 1'b1);
        chk("stream:accepted", acc, NR);
        check_job("stream");
        check_stream("stream");
        @(negedge aclk);
        chk("stream:busy_after", busy, 1'b0);
        @(posedge aclk); #1;

        // Valid held high with 0xA0.. data: ready never drops, order preserved.
        fill_vals(NR, 0, 32'hA0);
        clear_logs();
        run_job(NR, 0, -1, 0, acc, sd);
        chk("bp:done_seen", sd, 1'b1);
        chk("bp:accepted", acc, NR);
        check_job("bp");
        check_stream("bp");

        // Overrun with random gaps and a spurious start during RUN.
        fill_vals(NR + 4, 1, 32'h0);
        clear_logs();
        run_job(NR + 4, 2, 5, 0, acc, sd);
        chk("ovr:done_seen", sd, 1'b1);
        chk("ovr:accepted", acc, NR);
        chk("ovr:nacc_edges", a_edge.size(), NR);
        check_job("ovr");

        // Random jobs.
        for (int j = 0; j < 3; j++) begin
            nb = NR + $urandom_range(0, 3);
            gm = $urandom_range(0, 3);
            tg = $sformatf("rnd%0d", j);
            fill_vals(nb, 1, 32'h0);
            clear_logs();
            run_job(nb, gm, $urandom_range(0, 20), 0, acc, sd);
            chk({tg, ":done_seen"}, sd, 1'b1);
            chk({tg, ":accepted"}, acc, NR);
            check_job(tg);
        end

        // Abort after 5 writes.
        fill_vals(NR, 1, 32'h0);
        clear_logs();
        run_job(NR, 1, -1, 5, acc, sd);
        @(negedge aclk);
        chk("abort:we", BRAM_WE, 4'h0);
        chk("abort:addr", BRAM_ADDR, 32'h0);
        chk("abort:busy", busy, 1'b0);
        chk("abort:ready", rif.res_ready, 1'b0);
        chk("abort:done", done, 1'b0);
        chk("abort:nwrites", w_data.size(), 5);
        for (int i = 0; i < 5 && i < w_data.size(); i++)
            chk($sformatf("abort:data%0d", i), w_data[i], vals[i]);
        @(posedge aclk); #1;
        areset = 1'b0;
        rif.res_valid = 1'b1;
        rif.res_data  = 32'hDEAD_BEEF;
        repeat (10) @(posedge aclk);
        #1;
        rif.res_valid = 1'b0;
        chk("abort:idle_nwrites", w_data.size(), 5);
        chk("abort:idle_ndone", d_cyc.size(), 0);
        fill_vals(NR, 1, 32'h0);
        clear_logs();
        run_job(NR, 1, -1, 0, acc, sd);
        chk("rejob:done_seen", sd, 1'b1);
        check_job("rejob");

        repeat (3) @(posedge aclk);
        chk("global:we_value", bad_we, 0);
        chk("global:idle_addr", bad_idle_addr, 0);
        chk("global:ready_idle", bad_ready, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
